// File: rtl/fp32_addmul_unit_if.sv
// Operand/result bundle for the binary32 add/subtract/multiply unit.
interface fp32_addmul_unit_if;
    logic        in_valid;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        invalid;

    modport master (output in_valid, op, a, b,
                    input  out_valid, result, overflow, underflow, invalid);
    modport slave  (input  in_valid, op, a, b,
                    output out_valid, result, overflow, underflow, invalid);
endinterface

// File: rtl/fp32_addmul_unit.sv
// Registered binary32 add/sub/multiply: combinational datapath, one output register stage.
// Subnormals are flushed to zero on input and output; rounding is nearest-even.
module fp32_addmul_unit (
    input  logic              clk,
    input  logic              rst_n,
    fp32_addmul_unit_if.slave bus
);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inv;
    } fp_out_t;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd27;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(26 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // mant: bit 26 is the hidden one, bits 2/1/0 are guard/round/sticky
    function automatic fp_out_t round_pack(input logic sign, input logic signed [9:0] exp_in,
                                           input logic [26:0] mant);
        fp_out_t           o;
        logic [24:0]       rnd;
        logic signed [9:0] e;
        logic              inc;
        inc = mant[2] & (mant[1] | mant[0] | mant[3]);
        rnd = {1'b0, mant[26:3]} + {24'd0, inc};
        e   = exp_in;
        if (rnd[24]) begin
            rnd = rnd >> 1;
            e   = e + 10'sd1;
        end
        o = '0;
        if (e >= 10'sd255) begin
            o.res = {sign, 8'hFF, 23'd0};
            o.ovf = 1'b1;
        end else if (e <= 10'sd0) begin
            o.res = {sign, 31'd0};
            o.unf = 1'b1;
        end else begin
            o.res = {sign, e[7:0], rnd[22:0]};
        end
        return o;
    endfunction

    // Stage p0: operand decode and combinational datapath
    logic        sa_p0, sb_p0, sbm_p0;
    logic [7:0]  ea_p0, eb_p0;
    logic [23:0] ma_p0, mb_p0;
    logic        za_p0, zb_p0, ia_p0, ib_p0, na_p0, nb_p0;

    assign sa_p0  = bus.a[31];
    assign sbm_p0 = bus.b[31];
    assign sb_p0  = bus.b[31] ^ (bus.op == 2'b01);
    assign ea_p0  = bus.a[30:23];
    assign eb_p0  = bus.b[30:23];
    assign za_p0  = (ea_p0 == 8'd0);
    assign zb_p0  = (eb_p0 == 8'd0);
    assign ma_p0  = za_p0 ? 24'd0 : {1'b1, bus.a[22:0]};
    assign mb_p0  = zb_p0 ? 24'd0 : {1'b1, bus.b[22:0]};
    assign ia_p0  = (ea_p0 == 8'hFF) && (bus.a[22:0] == 23'd0);
    assign ib_p0  = (eb_p0 == 8'hFF) && (bus.b[22:0] == 23'd0);
    assign na_p0  = (ea_p0 == 8'hFF) && (bus.a[22:0] != 23'd0);
    assign nb_p0  = (eb_p0 == 8'hFF) && (bus.b[22:0] != 23'd0);

    logic              swap_p0, sbig_p0, ssml_p0;
    logic [7:0]        ebig_p0, esml_p0, dexp_p0;
    logic [26:0]       big_p0, sml_p0, shf_p0, nadd_p0;
    logic [27:0]       sum_p0;
    logic [4:0]        lz_p0;
    logic signed [9:0] eadd_p0;
    fp_out_t           add_p0;

    always_comb begin
        swap_p0 = {eb_p0, mb_p0} > {ea_p0, ma_p0};
        sbig_p0 = swap_p0 ? sb_p0 : sa_p0;
        ssml_p0 = swap_p0 ? sa_p0 : sb_p0;
        ebig_p0 = swap_p0 ? eb_p0 : ea_p0;
        esml_p0 = swap_p0 ? ea_p0 : eb_p0;
        big_p0  = {(swap_p0 ? mb_p0 : ma_p0), 3'b000};
        sml_p0  = {(swap_p0 ? ma_p0 : mb_p0), 3'b000};
        dexp_p0 = ebig_p0 - esml_p0;
        if (dexp_p0 >= 8'd27)
            shf_p0 = {26'd0, |sml_p0};
        else
            shf_p0 = (sml_p0 >> dexp_p0) | {26'd0, |(sml_p0 & ~(27'h7FF_FFFF << dexp_p0))};
        sum_p0 = (sbig_p0 != ssml_p0) ? ({1'b0, big_p0} - {1'b0, shf_p0})
                                      : ({1'b0, big_p0} + {1'b0, shf_p0});
        lz_p0  = lzc27(sum_p0[26:0]);
        if (sum_p0[27]) begin
            nadd_p0 = {sum_p0[27:2], sum_p0[1] | sum_p0[0]};
            eadd_p0 = $signed({2'b00, ebig_p0}) + 10'sd1;
        end else begin
            nadd_p0 = sum_p0[26:0] << lz_p0;
            eadd_p0 = $signed({2'b00, ebig_p0}) - $signed({5'd0, lz_p0});
        end
        add_p0 = round_pack(sbig_p0, eadd_p0, nadd_p0);
        if (na_p0 || nb_p0)
            add_p0 = '{res: QNAN, ovf: 1'b0, unf: 1'b0, inv: 1'b1};
        else if (ia_p0 && ib_p0)
            add_p0 = (sa_p0 != sb_p0) ? '{res: QNAN, ovf: 1'b0, unf: 1'b0, inv: 1'b1}
                                      : '{res: {sa_p0, 8'hFF, 23'd0}, ovf: 1'b0, unf: 1'b0, inv: 1'b0};
        else if (ia_p0)
            add_p0 = '{res: {sa_p0, 8'hFF, 23'd0}, ovf: 1'b0, unf: 1'b0, inv: 1'b0};
        else if (ib_p0)
            add_p0 = '{res: {sb_p0, 8'hFF, 23'd0}, ovf: 1'b0, unf: 1'b0, inv: 1'b0};
        else if (za_p0 && zb_p0)
            add_p0 = '{res: {sa_p0 & sb_p0, 31'd0}, ovf: 1'b0, unf: 1'b0, inv: 1'b0};
        else if (sum_p0 == 28'd0)
            add_p0 = '0;
    end

    logic              smul_p0;
    logic [47:0]       prod_p0;
    logic [26:0]       nmul_p0;
    logic signed [9:0] emul_p0;
    fp_out_t           mul_p0;

    always_comb begin
        smul_p0 = sa_p0 ^ sbm_p0;
        prod_p0 = {24'd0, ma_p0} * {24'd0, mb_p0};
        emul_p0 = $signed({2'b00, ea_p0}) + $signed({2'b00, eb_p0}) - 10'sd127
                  + $signed({9'd0, prod_p0[47]});
        nmul_p0 = prod_p0[47] ? {prod_p0[47:22], |prod_p0[21:0]}
                              : {prod_p0[46:21], |prod_p0[20:0]};
        mul_p0  = round_pack(smul_p0, emul_p0, nmul_p0);
        if (na_p0 || nb_p0 || ((ia_p0 || ib_p0) && (za_p0 || zb_p0)))
            mul_p0 = '{res: QNAN, ovf: 1'b0, unf: 1'b0, inv: 1'b1};
        else if (ia_p0 || ib_p0)
            mul_p0 = '{res: {smul_p0, 8'hFF, 23'd0}, ovf: 1'b0, unf: 1'b0, inv: 1'b0};
        else if (za_p0 || zb_p0)
            mul_p0 = '{res: {smul_p0, 31'd0}, ovf: 1'b0, unf: 1'b0, inv: 1'b0};
    end

    fp_out_t out_p0;
    assign out_p0 = bus.op[1] ? mul_p0 : add_p0;

    // Stage p1: output register; data holds when no new operation arrives
    logic        vld_p1;
    logic [31:0] res_p1;
    logic        ovf_p1, unf_p1, inv_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            res_p1 <= 32'd0;
            ovf_p1 <= 1'b0;
            unf_p1 <= 1'b0;
            inv_p1 <= 1'b0;
        end else begin
            vld_p1 <= bus.in_valid;
            if (bus.in_valid) begin
                res_p1 <= out_p0.res;
                ovf_p1 <= out_p0.ovf;
                unf_p1 <= out_p0.unf;
                inv_p1 <= out_p0.inv;
            end
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.result    = res_p1;
    assign bus.overflow  = ovf_p1;
    assign bus.underflow = unf_p1;
    assign bus.invalid   = inv_p1;
endmodule

// File: tb/tb_fp32_addmul_unit.sv
// Scoreboard bench for fp32_addmul_unit: directed vectors with hand-computed results.
module tb_fp32_addmul_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cycle = 0;
    int   checks = 0;
    int   failures = 0;

    fp32_addmul_unit_if bus ();

    fp32_addmul_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        int          idx;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inv;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_issued = 0;

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic o, input logic u, input logic i);
        exp_t e;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        e = '{idx: n_issued, res: r, ovf: o, unf: u, inv: i, cyc: cycle};
        exp_q.push_back(e);
        n_issued++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    // Monitor: every presented result must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL stale_out_valid: result=%h with no operation outstanding", bus.result);
            end else begin
                e = exp_q.pop_front();
                if (bus.result !== e.res || bus.overflow !== e.ovf ||
                    bus.underflow !== e.unf || bus.invalid !== e.inv) begin
                    failures++;
                    $display("FAIL vec%0d: got %h ovf=%b unf=%b inv=%b, want %h ovf=%b unf=%b inv=%b",
                             e.idx, bus.result, bus.overflow, bus.underflow, bus.invalid,
                             e.res, e.ovf, e.unf, e.inv);
                end
                checks++;
                if (cycle != e.cyc + 1) begin
                    failures++;
                    $display("FAIL vec%0d_latency: got %0d cycles, want 1", e.idx, cycle - e.cyc);
                end
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.op       = 2'b00;
        bus.a        = 32'd0;
        bus.b        = 32'd0;

        #12;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.result !== 32'd0 || bus.overflow !== 1'b0 ||
            bus.underflow !== 1'b0 || bus.invalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: out_valid=%b result=%h, want 0 and 00000000",
                     bus.out_valid, bus.result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Back-to-back stream of directed vectors
        issue(2'b00, 32'h3FC00000, 32'h40200000, 32'h40800000, 0, 0, 0);
        issue(2'b00, 32'h40000000, 32'hBF800000, 32'h3F800000, 0, 0, 0);
        issue(2'b01, 32'h40400000, 32'h3F800000, 32'h40000000, 0, 0, 0);
        issue(2'b00, 32'h40400000, 32'hC0400000, 32'h00000000, 0, 0, 0);
        issue(2'b10, 32'h3FC00000, 32'h40000000, 32'h40400000, 0, 0, 0);
        issue(2'b10, 32'h3F800000, 32'hBF800000, 32'hBF800000, 0, 0, 0);
        issue(2'b10, 32'h3F800001, 32'h3F800001, 32'h3F800002, 0, 0, 0);
        issue(2'b10, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 1, 0, 0);
        issue(2'b10, 32'h00800000, 32'h3F000000, 32'h00000000, 0, 1, 0);
        issue(2'b10, 32'h00000000, 32'h7F800000, 32'h7FC00000, 0, 0, 1);
        issue(2'b01, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 0, 0, 1);
        idle(2);
        issue(2'b00, 32'h80000000, 32'h80000000, 32'h80000000, 0, 0, 0);
        issue(2'b11, 32'h40000000, 32'h40400000, 32'h40C00000, 0, 0, 0);
        issue(2'b00, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 0, 0, 1);
        issue(2'b00, 32'h7F800000, 32'h3F800000, 32'h7F800000, 0, 0, 0);
        issue(2'b00, 32'h3F800000, 32'h33800000, 32'h3F800000, 0, 0, 0);
        issue(2'b00, 32'h3F800001, 32'h33800000, 32'h3F800002, 0, 0, 0);
        issue(2'b00, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1, 0, 0);
        issue(2'b10, 32'hC0000000, 32'h40400000, 32'hC0C00000, 0, 0, 0);

        // Operation in flight when reset asserts is discarded
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = 2'b00;
        bus.a        = 32'h3F800000;
        bus.b        = 32'h3F800000;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.result !== 32'd0 || bus.overflow !== 1'b0 ||
            bus.underflow !== 1'b0 || bus.invalid !== 1'b0) begin
            failures++;
            $display("FAIL midstream_reset: out_valid=%b result=%h, want 0 and 00000000",
                     bus.out_valid, bus.result);
        end
        idle(2);
        rst_n = 1'b1;
        idle(3);
        checks++;
        if (bus.result !== 32'd0) begin
            failures++;
            $display("FAIL post_reset_hold: result=%h, want 00000000", bus.result);
        end

        issue(2'b01, 32'h40000000, 32'h40400000, 32'hBF800000, 0, 0, 0);
        idle(1);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d results outstanding, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
